// File: rtl/legv8_pkg.sv
// Shared definitions for the LEGv8 front end: PC width, NOP encoding and
// the fetch-unit state encoding.
package legv8_pkg;

    localparam int PC_W = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } fetch_state_e;

endpackage

// File: rtl/if_skid_buffer.sv
// One-entry skid register that parks the in-flight memory word while decode
// is stalled, and selects between that word and the live memory output.
module if_skid_buffer
    import legv8_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            capture_i,
    input  logic            release_i,
    input  logic            flush_i,
    input  logic [31:0]     live_instr_i,
    input  logic [PC_W-1:0] live_pc_i,
    input  logic            live_valid_i,
    output logic [31:0]     src_instr_o,
    output logic [PC_W-1:0] src_pc_o,
    output logic            src_valid_o
);

    logic [31:0]     skid_instr_q, skid_instr_d;
    logic [PC_W-1:0] skid_pc_q,    skid_pc_d;
    logic            skid_valid_q, skid_valid_d;

    // A full skid entry is never overwritten; flush wins over everything.
    always_comb begin
        skid_instr_d = skid_instr_q;
        skid_pc_d    = skid_pc_q;
        skid_valid_d = skid_valid_q;
        if (flush_i) begin
            skid_valid_d = 1'b0;
        end else if (capture_i && !skid_valid_q) begin
            skid_instr_d = live_instr_i;
            skid_pc_d    = live_pc_i;
            skid_valid_d = 1'b1;
        end else if (release_i) begin
            skid_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_instr_q <= NOP_INSTR;
            skid_pc_q    <= '0;
            skid_valid_q <= 1'b0;
        end else begin
            skid_instr_q <= skid_instr_d;
            skid_pc_q    <= skid_pc_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign src_instr_o = skid_valid_q ? skid_instr_q : live_instr_i;
    assign src_pc_o    = skid_valid_q ? skid_pc_q    : live_pc_i;
    assign src_valid_o = skid_valid_q | live_valid_i;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: drives a one-cycle-latency instruction memory,
// tracks the in-flight fetch, and feeds decode with stall and redirect support.
module instruction_fetch_unit
    import legv8_pkg::*;
#(
    parameter logic [PC_W-1:0] PC_RESET = 32'h0,
    parameter logic [PC_W-1:0] PC_STEP  = 32'd1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [PC_W-1:0] branch_target,
    output logic [PC_W-1:0] imem_addr,
    input  logic [31:0]     imem_data,
    output logic [31:0]     id_instr,
    output logic [PC_W-1:0] id_pc,
    output logic            id_valid,
    output logic [15:0]     fetch_count
);

    fetch_state_e    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] f_pc_q, f_pc_d;
    logic            f_valid_q, f_valid_d;
    logic [31:0]     id_instr_q, id_instr_d;
    logic [PC_W-1:0] id_pc_q, id_pc_d;
    logic            id_valid_q, id_valid_d;
    logic [15:0]     count_q, count_d;

    logic            issue;
    logic            capture;
    logic [31:0]     src_instr;
    logic [PC_W-1:0] src_pc;
    logic            src_valid;

    assign issue   = !branch_taken && !stall;
    assign capture = !branch_taken && stall && (state_q == ST_RUN);

    if_skid_buffer u_skid (
        .clk          (clk),
        .rst_n        (rst_n),
        .capture_i    (capture),
        .release_i    (issue),
        .flush_i      (branch_taken),
        .live_instr_i (imem_data),
        .live_pc_i    (f_pc_q),
        .live_valid_i (f_valid_q),
        .src_instr_o  (src_instr),
        .src_pc_o     (src_pc),
        .src_valid_o  (src_valid)
    );

    // Redirect has priority over stall; a stall only changes state in RUN,
    // where the skid buffer grabs the word already returning from memory.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        f_pc_d     = f_pc_q;
        f_valid_d  = f_valid_q;
        id_instr_d = id_instr_q;
        id_pc_d    = id_pc_q;
        id_valid_d = id_valid_q;
        count_d    = count_q;
        if (branch_taken) begin
            pc_d       = branch_target;
            f_valid_d  = 1'b0;
            id_valid_d = 1'b0;
            state_d    = ST_FILL;
        end else if (stall) begin
            if (state_q == ST_RUN) begin
                state_d = ST_HOLD;
            end
        end else begin
            pc_d       = pc_q + PC_STEP;
            f_pc_d     = pc_q;
            f_valid_d  = 1'b1;
            id_instr_d = src_instr;
            id_pc_d    = src_pc;
            id_valid_d = src_valid;
            if (src_valid) begin
                count_d = count_q + 16'd1;
            end
            state_d    = ST_RUN;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_FILL;
            pc_q       <= PC_RESET;
            f_pc_q     <= '0;
            f_valid_q  <= 1'b0;
            id_instr_q <= NOP_INSTR;
            id_pc_q    <= '0;
            id_valid_q <= 1'b0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            f_pc_q     <= f_pc_d;
            f_valid_q  <= f_valid_d;
            id_instr_q <= id_instr_d;
            id_pc_q    <= id_pc_d;
            id_valid_q <= id_valid_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr   = pc_q;
    assign id_instr    = id_instr_q;
    assign id_pc       = id_pc_q;
    assign id_valid    = id_valid_q;
    assign fetch_count = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios plus a
// randomized phase, compared against a stream-level model of delivered words.
module tb_instruction_fetch_unit;

    logic        clk;
    logic        rst_n, stall, branch_taken;
    logic [31:0] branch_target, imem_addr, imem_data, id_instr, id_pc;
    logic        id_valid;
    logic [15:0] fetch_count;

    logic        rst2_n;
    logic [31:0] imem_addr2, imem_data2, id_instr2, id_pc2;
    logic        id_valid2;
    logic [15:0] fetch_count2;

    int vectors;
    int miscompares;

    // Model: next address to deliver, bubbles left before delivery resumes,
    // and the expected decode-side outputs.
    logic [31:0] mNext, mPc, mInstr;
    int          mBubbles;
    logic        mValid;
    logic [15:0] mCount;

    localparam logic [31:0] WRAP_RESET = 32'hFFFF_FFFE;

    instruction_fetch_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .imem_addr     (imem_addr),
        .imem_data     (imem_data),
        .id_instr      (id_instr),
        .id_pc         (id_pc),
        .id_valid      (id_valid),
        .fetch_count   (fetch_count)
    );

    instruction_fetch_unit #(.PC_RESET(WRAP_RESET)) dutWrap (
        .clk           (clk),
        .rst_n         (rst2_n),
        .stall         (1'b0),
        .branch_taken  (1'b0),
        .branch_target (32'h0),
        .imem_addr     (imem_addr2),
        .imem_data     (imem_data2),
        .id_instr      (id_instr2),
        .id_pc         (id_pc2),
        .id_valid      (id_valid2),
        .fetch_count   (fetch_count2)
    );

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return 32'h1000_0000 + a;
    endfunction

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Registered-read instruction memories, one per DUT.
    always @(posedge clk) begin
        imem_data  <= memWord(imem_addr);
        imem_data2 <= memWord(imem_addr2);
    end

    task automatic compare(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mNext    = 32'h0;
        mBubbles = 1;
        mValid   = 1'b0;
        mPc      = 32'h0;
        mInstr   = 32'h0;
        mCount   = 16'h0;
    endtask

    // Drive one cycle of inputs, then advance the model by the same edge.
    task automatic applyStimulus(input logic st, input logic br, input logic [31:0] tgt);
        stall         = st;
        branch_taken  = br;
        branch_target = tgt;
        @(posedge clk);
        if (br) begin
            mNext    = tgt;
            mBubbles = 1;
            mValid   = 1'b0;
        end else if (!st) begin
            if (mBubbles > 0) begin
                mBubbles--;
            end else begin
                mValid = 1'b1;
                mPc    = mNext;
                mInstr = memWord(mNext);
                mNext  = mNext + 32'd1;
                mCount = mCount + 16'd1;
            end
        end
        #1;
    endtask

    task automatic checkOutput(input string tag);
        compare({tag, ".valid"}, {31'h0, id_valid}, {31'h0, mValid});
        compare({tag, ".count"}, {16'h0, fetch_count}, {16'h0, mCount});
        if (mValid) begin
            compare({tag, ".pc"}, id_pc, mPc);
            compare({tag, ".instr"}, id_instr, mInstr);
        end
    endtask

    task automatic checkReset(input string tag);
        compare({tag, ".valid"}, {31'h0, id_valid}, 32'h0);
        compare({tag, ".count"}, {16'h0, fetch_count}, 32'h0);
        compare({tag, ".pc"}, id_pc, 32'h0);
        compare({tag, ".instr"}, id_instr, 32'h0);
        compare({tag, ".addr"}, imem_addr, 32'h0);
    endtask

    task automatic releaseReset();
        @(negedge clk);
        rst_n         = 1'b1;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        modelReset();
    endtask

    initial begin
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        rst2_n        = 1'b0;
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkReset("reset");
        releaseReset();

        // Straight-line fetch after reset: 0,1,2,3.
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("run");
        end

        // Restart, reach id_pc=2, then stall three cycles.
        rst_n = 1'b0;
        #1;
        checkReset("reset2");
        releaseReset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("pre_stall");
        end
        compare("stall_at_pc", id_pc, 32'd2);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, 32'h0);
            checkOutput("stall");
        end
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("release");
        end
        compare("branch_at_pc", id_pc, 32'd5);

        // Redirect to 20: two bubbles, then the target word.
        applyStimulus(1'b0, 1'b1, 32'd20);
        checkOutput("br_edge");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("br_bubble");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("br_target");
        compare("br_target_pc", id_pc, 32'd20);
        compare("br_target_instr", id_instr, 32'h1000_0014);

        // Redirect while in HOLD with the skid full.
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("hold");
        applyStimulus(1'b1, 1'b1, 32'd9);
        checkOutput("hold_br");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("hold_br_bubble");
        applyStimulus(1'b0, 1'b0, 32'h0);
        checkOutput("hold_br_target");
        compare("hold_br_pc", id_pc, 32'd9);

        // Asynchronous reset in the middle of a stall with the skid full.
        applyStimulus(1'b1, 1'b0, 32'h0);
        applyStimulus(1'b1, 1'b0, 32'h0);
        checkOutput("pre_reset_hold");
        #3;
        rst_n = 1'b0;
        #1;
        checkReset("async_reset");
        modelReset();
        releaseReset();
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'b0, 1'b0, 32'h0);
            checkOutput("restart");
        end
        compare("restart_pc", id_pc, 32'd0);

        // Randomized stalls and redirects.
        for (int i = 0; i < 400; i++) begin
            logic st, br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 99) < 30);
            br  = ($urandom_range(0, 99) < 7);
            tgt = ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 4000));
            applyStimulus(st, br, tgt);
            checkOutput("random");
        end

        // PC and fetch counter wrap on the second instance.
        @(negedge clk);
        rst2_n = 1'b1;
        for (int k = 1; k <= 65537; k++) begin
            @(posedge clk);
            #1;
            if (k == 1) begin
                compare("wrap.first_valid", {31'h0, id_valid2}, 32'h0);
            end else if (k <= 4 || k >= 65535) begin
                compare("wrap.valid", {31'h0, id_valid2}, 32'h1);
                compare("wrap.pc", id_pc2, WRAP_RESET + 32'(k - 2));
                compare("wrap.instr", id_instr2, memWord(WRAP_RESET + 32'(k - 2)));
                compare("wrap.count", {16'h0, fetch_count2}, {16'h0, 16'(k - 1)});
            end
        end
        compare("wrap.count_zero", {16'h0, fetch_count2}, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
